// File: rtl/memory_stage.sv
// Pipeline MEM stage: issues data-memory loads/stores, formats load data and registers results
// for Writeback, stalling upstream while a load is outstanding.
module memory_stage #(
    parameter int unsigned AddrWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    input  logic [31:0]          in_program_counter_i,
    input  logic [31:0]          in_result_i,
    input  logic [31:0]          in_store_data_i,
    input  logic [4:0]           in_dest_reg_i,
    input  logic                 in_read_enable_i,
    input  logic                 in_write_enable_i,
    input  logic [1:0]           in_width_i,
    input  logic                 in_signed_i,
    output logic                 mem_stall_o,
    output logic                 dmem_req_valid_o,
    input  logic                 dmem_req_ready_i,
    output logic [AddrWidth-1:0] dmem_addr_o,
    output logic                 dmem_write_o,
    output logic [3:0]           dmem_byte_enable_o,
    output logic [31:0]          dmem_write_data_o,
    input  logic                 dmem_resp_valid_i,
    input  logic [31:0]          dmem_resp_data_i,
    output logic                 out_valid_o,
    output logic [31:0]          out_program_counter_o,
    output logic [4:0]           out_dest_reg_o,
    output logic [31:0]          out_data_o,
    output logic                 out_misaligned_o
);
    typedef enum logic [1:0] {StIdle, StWaitResp, StDrain} state_e;

    state_e      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_mis_q, out_mis_d;
    logic [1:0]  ld_offset_q, ld_offset_d;
    logic [1:0]  ld_width_q, ld_width_d;
    logic        ld_signed_q, ld_signed_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic [31:0] ld_pc_q, ld_pc_d;

    logic [1:0]  offset;
    logic        is_half, is_word, mem_op, misaligned, req_valid, mem_stall;
    logic [31:0] resp_shifted, load_data;

    assign offset     = in_result_i[1:0];
    assign is_half    = (in_width_i == 2'd1);
    assign is_word    = in_width_i[1];
    assign mem_op     = in_valid_i & (in_read_enable_i | in_write_enable_i) & ~flush_i;
    assign misaligned = mem_op & ((is_half & offset[0]) | (is_word & (offset != 2'b00)));

    assign dmem_addr_o  = {in_result_i[AddrWidth-1:2], 2'b00};
    assign dmem_write_o = in_write_enable_i;

    always_comb begin
        dmem_write_data_o  = in_store_data_i;
        dmem_byte_enable_o = 4'b1111;
        case (in_width_i)
            2'd0: begin
                dmem_write_data_o  = {4{in_store_data_i[7:0]}};
                dmem_byte_enable_o = 4'b0001 << offset;
            end
            2'd1: begin
                dmem_write_data_o  = {2{in_store_data_i[15:0]}};
                dmem_byte_enable_o = 4'b0011 << offset;
            end
            default: ;
        endcase
        if (!in_write_enable_i) dmem_byte_enable_o = 4'b0000;
    end

    assign resp_shifted = dmem_resp_data_i >> {ld_offset_q, 3'b000};

    always_comb begin
        case (ld_width_q)
            2'd0: load_data = ld_signed_q ? {{24{resp_shifted[7]}}, resp_shifted[7:0]}
                                          : {24'd0, resp_shifted[7:0]};
            2'd1: load_data = ld_signed_q ? {{16{resp_shifted[15]}}, resp_shifted[15:0]}
                                          : {16'd0, resp_shifted[15:0]};
            default: load_data = dmem_resp_data_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        req_valid   = 1'b0;
        mem_stall   = 1'b0;
        out_valid_d = 1'b0;
        out_mis_d   = 1'b0;
        out_pc_d    = out_pc_q;
        out_rd_d    = out_rd_q;
        out_data_d  = out_data_q;
        ld_offset_d = ld_offset_q;
        ld_width_d  = ld_width_q;
        ld_signed_d = ld_signed_q;
        ld_rd_d     = ld_rd_q;
        ld_pc_d     = ld_pc_q;
        unique case (state_q)
            StIdle: begin
                req_valid = mem_op & ~misaligned;
                if (req_valid) begin
                    if (!dmem_req_ready_i) begin
                        mem_stall = 1'b1;
                    end else if (!in_write_enable_i) begin
                        mem_stall   = 1'b1;
                        state_d     = StWaitResp;
                        ld_offset_d = offset;
                        ld_width_d  = in_width_i;
                        ld_signed_d = in_signed_i;
                        ld_rd_d     = in_dest_reg_i;
                        ld_pc_d     = in_program_counter_i;
                    end
                end
                if (!mem_stall) begin
                    out_valid_d = in_valid_i & ~flush_i;
                    out_pc_d    = in_program_counter_i;
                    out_rd_d    = in_dest_reg_i;
                    out_data_d  = in_result_i;
                    out_mis_d   = misaligned;
                end
            end
            StWaitResp: begin
                if (dmem_resp_valid_i) begin
                    state_d = StIdle;
                    // A flush landing with the response still kills the load.
                    if (!flush_i) begin
                        out_valid_d = 1'b1;
                        out_pc_d    = ld_pc_q;
                        out_rd_d    = ld_rd_q;
                        out_data_d  = load_data;
                    end
                end else if (flush_i) begin
                    state_d = StDrain;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            StDrain: begin
                mem_stall = mem_op;
                if (dmem_resp_valid_i) state_d = StIdle;
                if (!mem_op) begin
                    out_valid_d = in_valid_i & ~flush_i;
                    out_pc_d    = in_program_counter_i;
                    out_rd_d    = in_dest_reg_i;
                    out_data_d  = in_result_i;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'd0;
            out_rd_q    <= 5'd0;
            out_data_q  <= 32'd0;
            out_mis_q   <= 1'b0;
            ld_offset_q <= 2'd0;
            ld_width_q  <= 2'd0;
            ld_signed_q <= 1'b0;
            ld_rd_q     <= 5'd0;
            ld_pc_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_rd_q    <= out_rd_d;
            out_data_q  <= out_data_d;
            out_mis_q   <= out_mis_d;
            ld_offset_q <= ld_offset_d;
            ld_width_q  <= ld_width_d;
            ld_signed_q <= ld_signed_d;
            ld_rd_q     <= ld_rd_d;
            ld_pc_q     <= ld_pc_d;
        end
    end

    assign mem_stall_o           = mem_stall;
    assign dmem_req_valid_o      = req_valid;
    assign out_valid_o           = out_valid_q;
    assign out_program_counter_o = out_pc_q;
    assign out_dest_reg_o        = out_rd_q;
    assign out_data_o            = out_data_q;
    assign out_misaligned_o      = out_mis_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus randomized traffic against a transaction-level
// model tracking owed responses and whether the owed load is still wanted.
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0, in_result = '0, in_sd = '0;
    logic [4:0]  in_rd = '0;
    logic        in_re = 1'b0, in_we = 1'b0, in_sgn = 1'b0;
    logic [1:0]  in_width = '0;
    logic        ready = 1'b0, resp_valid = 1'b0;
    logic [31:0] resp_data = '0;

    logic        mem_stall, req_valid, dmem_write, out_valid, out_mis;
    logic [31:0] dmem_addr, dmem_wd, out_pc, out_data;
    logic [3:0]  dmem_be;
    logic [4:0]  out_rd;

    int vectors = 0, miscompares = 0, stall_seen = 0;

    // Model: at most one response owed; "alive" says whether it must still reach Writeback.
    bit          m_owed = 0, m_alive = 0, m_stall = 0, m_acc = 0;
    logic [31:0] m_pc;
    logic [4:0]  m_rd;
    int unsigned m_off;
    logic [1:0]  m_width;
    bit          m_sgn;
    bit          e_valid = 0, e_mis = 0;
    logic [31:0] e_pc = '0, e_data = '0;
    logic [4:0]  e_rd = '0;

    memory_stage #(.AddrWidth(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .in_valid_i(in_valid),
        .in_program_counter_i(in_pc), .in_result_i(in_result), .in_store_data_i(in_sd),
        .in_dest_reg_i(in_rd), .in_read_enable_i(in_re), .in_write_enable_i(in_we),
        .in_width_i(in_width), .in_signed_i(in_sgn), .mem_stall_o(mem_stall),
        .dmem_req_valid_o(req_valid), .dmem_req_ready_i(ready), .dmem_addr_o(dmem_addr),
        .dmem_write_o(dmem_write), .dmem_byte_enable_o(dmem_be), .dmem_write_data_o(dmem_wd),
        .dmem_resp_valid_i(resp_valid), .dmem_resp_data_i(resp_data), .out_valid_o(out_valid),
        .out_program_counter_o(out_pc), .out_dest_reg_o(out_rd), .out_data_o(out_data),
        .out_misaligned_o(out_mis)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_instr(input bit v, input logic [31:0] pc, input logic [31:0] res,
                             input logic [31:0] sd, input logic [4:0] rd, input bit re,
                             input bit we, input logic [1:0] w, input bit s);
        in_valid = v; in_pc = pc; in_result = res; in_sd = sd; in_rd = rd;
        in_re = re; in_we = we; in_width = w; in_sgn = s;
    endtask

    // One clock cycle, entered and left at the falling edge with inputs already driven.
    task automatic step();
        bit          mop, mis, req, stall, acc, wb_ld, wb_in;
        int unsigned off, val;
        logic [31:0] exp_be, exp_wd;
        #1;
        off   = in_result[1:0];
        mop   = in_valid && (in_re || in_we) && !flush;
        mis   = mop && ((in_width == 2'd1 && off % 2 == 1) || (in_width >= 2'd2 && off != 0));
        req   = 0; stall = 0; acc = 0; wb_ld = 0; wb_in = 0;
        if (!m_owed) begin
            req   = mop && !mis;
            stall = req && (!ready || !in_we);
            acc   = req && ready && !in_we;
            wb_in = !stall;
        end else if (m_alive) begin
            if (resp_valid) wb_ld = !flush;
            else if (!flush) stall = 1;
        end else begin
            stall = mop;
            wb_in = !stall;
        end
        if (mem_stall === 1'b1) stall_seen++;
        check("mem_stall", {31'd0, mem_stall}, {31'd0, stall});
        check("req_valid", {31'd0, req_valid}, {31'd0, req});
        if (req) begin
            check("dmem_addr", dmem_addr, in_result & 32'hFFFF_FFFC);
            check("dmem_write", {31'd0, dmem_write}, {31'd0, in_we});
            if (!in_we) exp_be = 0;
            else if (in_width == 2'd0) exp_be = 32'd1 << off;
            else if (in_width == 2'd1) exp_be = 32'd3 << off;
            else exp_be = 32'd15;
            check("byte_enable", {28'd0, dmem_be}, exp_be);
            if (in_we) begin
                if (in_width == 2'd0) exp_wd = (in_sd & 32'hFF) * 32'h0101_0101;
                else if (in_width == 2'd1) exp_wd = (in_sd & 32'hFFFF) * 32'h0001_0001;
                else exp_wd = in_sd;
                check("write_data", dmem_wd, exp_wd);
            end
        end
        val = resp_data >> (8 * m_off);
        if (m_width == 2'd0) begin
            val = val & 32'hFF;
            if (m_sgn && val >= 128) val = val - 256;
        end else if (m_width == 2'd1) begin
            val = val & 32'hFFFF;
            if (m_sgn && val >= 32768) val = val - 65536;
        end else begin
            val = resp_data;
        end
        @(posedge clk);
        if (wb_ld) begin
            e_valid = 1; e_pc = m_pc; e_rd = m_rd; e_data = val; e_mis = 0;
        end else if (wb_in) begin
            e_valid = in_valid && !flush; e_pc = in_pc; e_rd = in_rd;
            e_data = in_result; e_mis = mis;
        end else begin
            e_valid = 0;
        end
        if (!m_owed) begin
            if (acc) begin
                m_owed = 1; m_alive = 1; m_pc = in_pc; m_rd = in_rd;
                m_off = off; m_width = in_width; m_sgn = in_sgn;
            end
        end else if (m_alive) begin
            if (resp_valid) m_owed = 0;
            else if (flush) m_alive = 0;
        end else if (resp_valid) begin
            m_owed = 0;
        end
        m_stall = stall;
        m_acc   = acc;
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
        if (e_valid) begin
            check("out_pc", out_pc, e_pc);
            check("out_rd", {27'd0, out_rd}, {27'd0, e_rd});
            check("out_data", out_data, e_data);
            check("out_misaligned", {31'd0, out_mis}, {31'd0, e_mis});
        end
        @(negedge clk);
    endtask

    int unsigned cnt = 0;
    int unsigned kind;
    logic [31:0] addr;

    initial begin
        #2;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_data", out_data, 32'd0);
        check("reset mem_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        // LW 0x100, response three cycles after accept.
        set_instr(1, 32'h1000, 32'h100, 0, 5'd3, 1, 0, 2'd2, 0);
        ready = 1; stall_seen = 0;
        step(); step(); step();
        resp_valid = 1; resp_data = 32'hDEAD_BEEF;
        step();
        resp_valid = 0;
        check("t1 stall cycles", stall_seen, 32'd3);
        check("t1 out_data", out_data, 32'hDEAD_BEEF);
        check("t1 out_valid", {31'd0, out_valid}, 32'd1);

        // LB / LBU at 0x103.
        set_instr(1, 32'h1004, 32'h103, 0, 5'd4, 1, 0, 2'd0, 1);
        step();
        resp_valid = 1; resp_data = 32'h80FF_FF7F;
        step();
        resp_valid = 0;
        check("t2 lb", out_data, 32'hFFFF_FF80);
        set_instr(1, 32'h1008, 32'h103, 0, 5'd5, 1, 0, 2'd0, 0);
        step();
        resp_valid = 1;
        step();
        resp_valid = 0;
        check("t2 lbu", out_data, 32'h0000_0080);

        // SH 0x202.
        set_instr(1, 32'h100C, 32'h202, 32'h1234_ABCD, 5'd0, 0, 1, 2'd1, 0);
        #1;
        check("t3 be", {28'd0, dmem_be}, 32'hC);
        check("t3 wdata", dmem_wd, 32'hABCD_ABCD);
        check("t3 stall", {31'd0, mem_stall}, 32'd0);
        step();

        // Misaligned LW.
        set_instr(1, 32'h1010, 32'h101, 0, 5'd6, 1, 0, 2'd2, 0);
        #1;
        check("t4 req_valid", {31'd0, req_valid}, 32'd0);
        step();
        check("t4 misaligned", {31'd0, out_mis}, 32'd1);
        check("t4 out_valid", {31'd0, out_valid}, 32'd1);

        // Flush while waiting, then drain.
        set_instr(1, 32'h1014, 32'h400, 0, 5'd7, 1, 0, 2'd2, 0);
        step();
        flush = 1;
        step();
        flush = 0;
        check("t5 flushed", {31'd0, out_valid}, 32'd0);
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        resp_valid = 1; resp_data = 32'h1111_2222;
        step();
        resp_valid = 0;
        check("t5 drained", {31'd0, out_valid}, 32'd0);
        set_instr(1, 32'h1018, 32'h55, 0, 5'd8, 0, 0, 2'd2, 0);
        step();
        check("t5 add valid", {31'd0, out_valid}, 32'd1);
        check("t5 add data", out_data, 32'h55);

        // Reset while waiting for a response; the late response must be ignored.
        set_instr(1, 32'h101C, 32'h300, 0, 5'd9, 1, 0, 2'd2, 0);
        step();
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_ni = 0;
        #1;
        check("t6 out_pc", out_pc, 32'd0);
        check("t6 out_data", out_data, 32'd0);
        check("t6 out_rd", {27'd0, out_rd}, 32'd0);
        check("t6 stall", {31'd0, mem_stall}, 32'd0);
        m_owed = 0; m_alive = 0; e_valid = 0;
        @(negedge clk);
        rst_ni = 1;
        resp_valid = 1; resp_data = 32'hCAFE_F00D;
        step();
        resp_valid = 0;
        check("t6 late resp", {31'd0, out_valid}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            resp_valid = 0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    resp_valid = 1;
                    resp_data  = $urandom;
                end
            end
            if (!m_stall) begin
                kind = $urandom_range(0, 9);
                addr = $urandom & 32'h0000_0FFF;
                in_width = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 3) != 0) begin
                    if (in_width == 2'd1) addr = addr & 32'hFFFF_FFFE;
                    else if (in_width != 2'd0) addr = addr & 32'hFFFF_FFFC;
                end
                in_valid  = ($urandom_range(0, 9) != 0);
                in_pc     = $urandom;
                in_result = addr;
                in_sd     = $urandom;
                in_rd     = 5'($urandom);
                in_sgn    = 1'($urandom);
                in_re     = (kind >= 4 && kind < 7);
                in_we     = (kind >= 7);
            end
            flush = ($urandom_range(0, 19) == 0);
            if (m_owed && m_alive && resp_valid) flush = 0;
            ready = ($urandom_range(0, 9) < 7);
            step();
            if (m_acc) cnt = $urandom_range(1, 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
